// File: rtl/noise_injector.sv
// rtl/noise_injector.sv - LFSR noise injector with saturating add for codec samples
module noise_injector #(
  parameter int          WIDTH      = 24,
  parameter int          NOISE_BITS = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bypass,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [15:0]      sat_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [15:0]      lfsr;
  logic             feedback;
  logic [WIDTH:0]   noise_ext;
  logic [WIDTH:0]   in_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat_value;
  logic             clipped;

  assign feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign noise_ext = {{(WIDTH + 1 - NOISE_BITS){lfsr[NOISE_BITS-1]}}, lfsr[NOISE_BITS-1:0]};
  assign in_ext    = {data_in[WIDTH-1], data_in};
  assign sum       = in_ext + noise_ext;

  // Clip: the sum fits in WIDTH+1 bits, so overflow shows as the top two bits disagreeing
  always_comb begin
    clipped   = 1'b0;
    sat_value = sum[WIDTH-1:0];
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      clipped   = 1'b1;
      sat_value = sum[WIDTH] ? MIN_VAL : MAX_VAL;
    end
  end

  // Noise generator steps once per consumed sample, bypassed or not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (enable) begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

  // Output sample register and its one-cycle valid strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= enable;
      if (enable) begin
        data_out <= bypass ? data_in : sat_value;
      end
    end
  end

  // Count clipped noisy samples, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (enable && !bypass && clipped && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: doc/noise_injector.md
NOISE_INJECTOR -- requirements
Module: noise_injector

Interface
REQ-001 Parameter WIDTH, default 24, sets the sample width in bits (signed two's complement, codec format).
REQ-002 Parameter NOISE_BITS, default 8, sets the noise magnitude width in bits; legal range 2..16.
REQ-003 Parameter SEED, default 16'hACE1, sets the LFSR reset value; it SHALL be nonzero.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  one-cycle sample strobe (codec read&write handshake); one sample consumed per high cycle.
REQ-007 bypass  input  1  when high, samples pass through without noise.
REQ-008 data_in  input  WIDTH  signed input sample from the codec left channel.
REQ-009 data_out  output  WIDTH  signed noisy sample, registered, feeding averaging-filter data_in.
REQ-010 out_valid  output  1  high for exactly one cycle when data_out has been updated.
REQ-011 sat_count  output  16  number of samples clipped since reset.

Function
REQ-012 LFSR: 16-bit Fibonacci register; feedback = q[15]^q[13]^q[12]^q[10]; next state = {q[14:0], feedback}.
REQ-013 LFSR advances only on cycles with enable=1, regardless of bypass; it holds otherwise.
REQ-014 Noise value = LFSR[NOISE_BITS-1:0] interpreted as signed, sign-extended to WIDTH+1; the LFSR value before the advance on that edge is used.
REQ-015 Sum = sign-extended data_in + noise, computed at WIDTH+1 bits; no intermediate truncation.
REQ-016 Saturation: sum > 2^(WIDTH-1)-1 yields 0x7FFFFF (for WIDTH=24); sum < -2^(WIDTH-1) yields 0x800000; otherwise sum[WIDTH-1:0].
REQ-017 On an edge with enable=1 and bypass=0, data_out SHALL load the saturated sum; latency is 1 cycle.
REQ-018 On an edge with enable=1 and bypass=1, data_out SHALL load data_in unchanged, and sat_count SHALL not change.
REQ-019 On an edge with enable=0, data_out and sat_count hold, and out_valid SHALL be 0 on the following cycle.
REQ-020 out_valid SHALL be a registered copy of enable: high in the cycle after each enable cycle; back-to-back enables give back-to-back valid pulses.
REQ-021 sat_count increments by 1 for each non-bypass sample whose result was clipped; it holds at 16'hFFFF (no wrap).
REQ-022 Changes to bypass take effect on the next enabled sample; no pipeline flush is required.
REQ-023 All outputs are registered; no combinational path runs from inputs to outputs.

Reset
REQ-024 While reset=1, asynchronously: LFSR=SEED, data_out=0, out_valid=0, sat_count=0.
REQ-025 Reset asserted mid-stream discards the pending sample; the first enable after release uses noise from SEED.
REQ-026 An enable coincident with reset SHALL be ignored.

Verification
REQ-027 The bench SHALL apply reset, then 4 consecutive enables (bypass=0) with data_in = 0x000000, 0x000100, 0x800010, 0x7FFFFA, and SHALL check the following responses.
- data_out sequence: 0xFFFFE1, 0x0000C3, 0x800000, 0x7FFFFF.
- Noise sequence: -31, -61, -121, +15.
- LFSR sequence: 0xACE1, 0x59C3, 0xB387, 0x670F.
- sat_count = 2 at the end.
REQ-028 Same stimulus with bypass=1 -> data_out equals each data_in one cycle later, sat_count=0, LFSR still reaches 0x670F after 3 advances.
REQ-029 Gapped enables (1 high, 3 low, repeated) -> out_valid exactly one cycle after each enable, data_out stable in gaps, LFSR advances only on enables.
REQ-030 Reset asserted between samples 2 and 3 of the REQ-027 sequence -> outputs go to 0 immediately, and the next sample uses noise -31.
REQ-031 Force sat_count to 16'hFFFF via 65535 clipped samples (data_in=0x7FFFFF, NOISE_BITS such that noise>0 occurs) -> count holds at 16'hFFFF.
REQ-032 Random stream of 10,000 samples -> data_out matches a reference model of REQ-012 to REQ-021 bit-exactly.
